// File: rtl/ps2_kbd_device_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_device_tx_if
// Brief    : Key-event input, host clock input and PS/2 line/status outputs
//            of the device-side PS/2 keyboard transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_kbd_device_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [10:0]                 ps2_key;
    logic                        ps2_clk_i;
    logic                        ps2_clk_o;
    logic                        ps2_data_o;
    logic                        busy;
    logic                        dropped;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Event source / host side
    modport master (
        output ps2_key,
        output ps2_clk_i,
        input  ps2_clk_o,
        input  ps2_data_o,
        input  busy,
        input  dropped,
        input  fifo_count
    );

    // Transmitter side
    modport slave (
        input  ps2_key,
        input  ps2_clk_i,
        output ps2_clk_o,
        output ps2_data_o,
        output busy,
        output dropped,
        output fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_device_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_device_tx
// Brief    : Device-side PS/2 keyboard transmitter. Expands ps2_key events
//            into Set-2 byte sequences, queues them in a byte FIFO and
//            serializes them as PS/2 frames, backing off on host inhibit.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_device_tx #(
    parameter int CLK_DIV    = 1000,
    parameter int GAP        = 2000,
    parameter int FIFO_DEPTH = 8
) (
    input  wire                clk_sys,
    input  wire                reset,
    ps2_kbd_device_tx_if.slave bus
);
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_CW      = c_AW + 1;
    localparam int c_CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP - 1);
    localparam logic [c_CW-1:0]    c_DEPTH    = c_CW'(FIFO_DEPTH);
    localparam logic [3:0]         c_IDX_STOP = 4'd10;

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_GAPWAIT = 2'd1;
    localparam logic [1:0] c_S_BIT_HI  = 2'd2;
    localparam logic [1:0] c_S_BIT_LO  = 2'd3;

    logic             r_toggle_ref, r_clk_meta, r_clk_s;
    logic             r_new_valid, r_ovf;
    logic [9:0]       r_new_key;
    logic [15:0]      r_rem;
    logic [1:0]       r_rem_cnt;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [1:0]       r_state, w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [7:0]       r_shift, r_retry_byte;
    logic             r_retry_valid;

    logic             w_event, w_enq_active, w_consume, w_space_drop, w_start;
    logic [7:0]       w_first, w_push_data;
    logic [15:0]      w_rem;
    logic [1:0]       w_rem_cnt;
    logic [c_CW-1:0]  w_len, w_free;
    logic             w_push, w_pop, w_launch, w_abort;
    logic [10:0]      w_frame;

    // Toggle reference tracks ps2_key[10]; host clock goes through two flops
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_toggle_ref <= bus.ps2_key[10];
            r_clk_meta   <= 1'b1;
            r_clk_s      <= 1'b1;
        end else begin
            r_toggle_ref <= bus.ps2_key[10];
            r_clk_meta   <= bus.ps2_clk_i;
            r_clk_s      <= r_clk_meta;
        end
    end

    assign w_event      = bus.ps2_key[10] ^ r_toggle_ref;
    assign w_enq_active = (r_rem_cnt != 2'd0);
    assign w_consume    = r_new_valid & ~w_enq_active;

    // Capture a new event; it waits here (one deep) while a sequence is being written
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_new_valid <= 1'b0;
            r_new_key   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_event) begin
                if (r_new_valid && !w_consume) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_new_valid <= 1'b1;
                    r_new_key   <= bus.ps2_key[9:0];
                end
            end else if (w_consume) begin
                r_new_valid <= 1'b0;
            end
        end
    end

    // Expand the captured event into its byte sequence: [E0] [F0] code
    always_comb begin
        w_first   = r_new_key[7:0];
        w_rem     = '0;
        w_rem_cnt = 2'd0;
        w_len     = c_CW'(1);
        case ({r_new_key[8], r_new_key[9]})
            2'b11: begin
                w_first   = 8'hE0;
                w_rem     = {8'h00, r_new_key[7:0]};
                w_rem_cnt = 2'd1;
                w_len     = c_CW'(2);
            end
            2'b10: begin
                w_first   = 8'hE0;
                w_rem     = {r_new_key[7:0], 8'hF0};
                w_rem_cnt = 2'd2;
                w_len     = c_CW'(3);
            end
            2'b00: begin
                w_first   = 8'hF0;
                w_rem     = {8'h00, r_new_key[7:0]};
                w_rem_cnt = 2'd1;
                w_len     = c_CW'(2);
            end
            default: ;
        endcase
    end

    // Whole sequences only: space is reserved up front, so later bytes never overflow
    assign w_free       = c_DEPTH - r_count;
    assign w_space_drop = w_consume & (w_free < w_len);
    assign w_start      = w_consume & ~w_space_drop;
    assign w_push       = w_start | w_enq_active;
    assign w_push_data  = w_enq_active ? r_rem[7:0] : w_first;

    // Remaining bytes of the sequence, written one per cycle
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_rem     <= '0;
            r_rem_cnt <= 2'd0;
        end else if (w_start) begin
            r_rem     <= w_rem;
            r_rem_cnt <= w_rem_cnt;
        end else if (w_enq_active) begin
            r_rem     <= {8'h00, r_rem[15:8]};
            r_rem_cnt <= r_rem_cnt - 2'd1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: ;
            endcase
        end
    end

    // A retried byte always goes before anything still queued
    assign w_launch = (r_state == c_S_IDLE) & r_clk_s & (r_retry_valid | (r_count != '0));
    assign w_pop    = w_launch & ~r_retry_valid;
    assign w_abort  = (r_state == c_S_BIT_HI) & ~r_clk_s & (r_idx != c_IDX_STOP);
    assign w_frame  = {1'b1, ~^r_shift, r_shift, 1'b0};

    // Serializer state register
    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= c_S_IDLE;
        else       r_state <= w_next_state;
    end

    // Serializer next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:    if (w_launch) w_next_state = c_S_BIT_HI;
            c_S_BIT_HI: begin
                if (w_abort)                  w_next_state = c_S_GAPWAIT;
                else if (r_cnt == c_DIV_LAST) w_next_state = c_S_BIT_LO;
            end
            c_S_BIT_LO: begin
                if (r_cnt == c_DIV_LAST)
                    w_next_state = (r_idx == c_IDX_STOP) ? c_S_GAPWAIT : c_S_BIT_HI;
            end
            c_S_GAPWAIT: if (r_cnt == c_GAP_LAST) w_next_state = c_S_IDLE;
            default:     w_next_state = c_S_IDLE;
        endcase
    end

    // Phase counter, bit index, shift register and retry register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt         <= '0;
            r_idx         <= 4'd0;
            r_shift       <= 8'h00;
            r_retry_valid <= 1'b0;
            r_retry_byte  <= 8'h00;
        end else begin
            if (r_state == c_S_IDLE || w_next_state != r_state) r_cnt <= '0;
            else                                                r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_launch) begin
                r_idx   <= 4'd0;
                r_shift <= r_retry_valid ? r_retry_byte : r_mem[r_rd_ptr];
            end else if (r_state == c_S_BIT_LO && w_next_state == c_S_BIT_HI) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_abort) begin
                r_retry_valid <= 1'b1;
                r_retry_byte  <= r_shift;
            end else if (w_launch) begin
                r_retry_valid <= 1'b0;
            end
        end
    end

    // Line drive: released outside a frame, clock low only in the low phase
    always_comb begin
        bus.ps2_clk_o  = 1'b1;
        bus.ps2_data_o = 1'b1;
        case (r_state)
            c_S_BIT_HI: bus.ps2_data_o = w_frame[r_idx];
            c_S_BIT_LO: begin
                bus.ps2_clk_o  = 1'b0;
                bus.ps2_data_o = w_frame[r_idx];
            end
            default: ;
        endcase
    end

    assign bus.busy       = (r_state != c_S_IDLE) | (r_count != '0) | r_retry_valid
                          | w_enq_active | r_new_valid;
    assign bus.dropped    = w_space_drop | r_ovf;
    assign bus.fifo_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_device_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_device_tx
// Brief    : Scoreboard bench for ps2_kbd_device_tx. Stimulus pushes the
//            expected Set-2 bytes per key event; a line monitor decodes
//            frames from ps2_clk_o/ps2_data_o and compares against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_device_tx;
    localparam int CLK_DIV    = 4;
    localparam int GAP        = 10;
    localparam int FIFO_DEPTH = 8;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    ps2_kbd_device_tx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    ps2_kbd_device_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP        (GAP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Scoreboard and monitor state
    logic [7:0]  exp_q[$];
    logic        par_log[$];
    logic        in_frame = 1'b0, await_end = 1'b0, timing_err = 1'b0;
    logic        prev_clk = 1'b1, prev_data = 1'b1;
    int          nbits = 0, start_cyc = 0, hi_run = 0, last_end = -100000;
    int          frames = 0, falls = 0, drops = 0, aborts = 0;
    logic [10:0] bits = '0, last_bits = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: decodes frames at ps2_clk_o falling edges
    always @(negedge clk_sys) begin
        if (reset) begin
            in_frame  = 1'b0;
            await_end = 1'b0;
            hi_run    = 0;
            nbits     = 0;
            last_end  = -100000;
            prev_clk  = 1'b1;
            prev_data = 1'b1;
        end else begin
            if (bus.dropped) drops++;
            if (!in_frame && prev_data && !bus.ps2_data_o) begin
                in_frame   = 1'b1;
                nbits      = 0;
                timing_err = 1'b0;
                start_cyc  = cyc;
                hi_run     = 0;
                chk("inter_frame_gap", 32'((cyc - last_end) >= GAP), 32'd1);
            end
            if (prev_clk && !bus.ps2_clk_o) begin
                falls++;
                if (!in_frame || await_end) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL clock_outside_frame: falling edge at cycle %0d", cyc);
                end else begin
                    bits[nbits] = bus.ps2_data_o;
                    if (cyc - start_cyc != (2 * nbits + 1) * CLK_DIV) timing_err = 1'b1;
                    nbits++;
                    if (nbits == 11) begin
                        await_end = 1'b1;
                        chk("start_bit", 32'(bits[0]), 32'd0);
                        chk("stop_bit", 32'(bits[10]), 32'd1);
                        chk("odd_parity", 32'(^bits[9:1]), 32'd1);
                        chk("bit_timing", 32'(timing_err), 32'd0);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_frame: got byte %0h, expected none", bits[8:1]);
                        end else begin
                            chk("frame_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
                        end
                        par_log.push_back(bits[9]);
                        last_bits = bits;
                        frames++;
                    end
                end
            end else if (!prev_clk && bus.ps2_clk_o && await_end) begin
                chk("frame_length", 32'(cyc - start_cyc), 32'(22 * CLK_DIV));
                last_end  = cyc;
                in_frame  = 1'b0;
                await_end = 1'b0;
            end
            // Both lines released mid-frame for longer than a half bit: aborted frame
            if (in_frame && !await_end && bus.ps2_clk_o && bus.ps2_data_o) begin
                hi_run++;
                if (hi_run > CLK_DIV + 1) begin
                    aborts++;
                    in_frame = 1'b0;
                    last_end = cyc - hi_run + 1;
                    hi_run   = 0;
                end
            end else begin
                hi_run = 0;
            end
            prev_clk  = bus.ps2_clk_o;
            prev_data = bus.ps2_data_o;
        end
    end

    // Reference model: Set-2 bytes of one event are [E0 if extended] [F0 if break] code
    task automatic send_event(input logic pressed, input logic ext, input logic [7:0] code,
                              input bit keep);
        if (keep) begin
            if (ext)      exp_q.push_back(8'hE0);
            if (!pressed) exp_q.push_back(8'hF0);
            exp_q.push_back(code);
        end
        bus.ps2_key = {~bus.ps2_key[10], pressed, ext, code};
    endtask

    task automatic wait_idle(input int limit, output int at);
        at = -1;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (!bus.busy) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, expected 0", bus.busy, limit);
        end
    endtask

    task automatic wait_falls(input int target, input int limit);
        int n;
        n = 0;
        while (falls < target && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
        if (falls < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_falls: saw %0d falling edges, expected %0d", falls, target);
        end
    endtask

    task automatic wait_clk_high(input int limit);
        int n;
        n = 0;
        while (!bus.ps2_clk_o && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, f0, f1, a0, d0, occ, exp_drops;
        logic rel_ok;
        logic [10:0] v;
        int seq_1c[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};

        reset         = 1'b1;
        bus.ps2_clk_i = 1'b1;
        bus.ps2_key   = 11'h400;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("reset_clk_o", 32'(bus.ps2_clk_o), 32'd1);
        chk("reset_data_o", 32'(bus.ps2_data_o), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_dropped", 32'(bus.dropped), 32'd0);
        chk("reset_fifo_count", 32'(bus.fifo_count), 32'd0);

        // Make 0x1C: exact bit sequence and busy release GAP cycles after the stop bit
        send_event(1'b1, 1'b0, 8'h1C, 1'b1);
        wait_idle(400, t);
        foreach (seq_1c[i]) v[i] = seq_1c[i][0];
        chk("frame_1c_bits", 32'(last_bits), 32'(v));
        chk("busy_drop_delay", 32'(t - last_end), 32'(GAP));

        // Extended break 0x74: E0, F0, 74 with parity bits 0, 1, 1
        par_log.delete();
        @(negedge clk_sys);
        send_event(1'b0, 1'b1, 8'h74, 1'b1);
        wait_idle(1000, t);
        chk("parity_e0_f0_74", 32'({par_log[0], par_log[1], par_log[2]}), 32'b011);

        // Codes 0x00 and 0xFF both carry parity bit 1
        par_log.delete();
        @(negedge clk_sys);
        send_event(1'b1, 1'b0, 8'h00, 1'b1);
        wait_idle(400, t);
        send_event(1'b1, 1'b0, 8'hFF, 1'b1);
        wait_idle(400, t);
        chk("parity_00_ff", 32'({par_log[0], par_log[1]}), 32'b11);

        // Host inhibit during data bit 3: release, then full resend after GAP
        a0 = aborts;
        f0 = falls;
        @(negedge clk_sys);
        send_event(1'b1, 1'b0, 8'h5A, 1'b1);
        wait_falls(f0 + 4, 400);
        wait_clk_high(50);
        bus.ps2_clk_i = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("inhibit_release", 32'({bus.ps2_clk_o, bus.ps2_data_o}), 32'b11);
        f1     = falls;
        rel_ok = 1'b1;
        repeat (30) begin
            @(negedge clk_sys);
            if (!bus.ps2_clk_o || !bus.ps2_data_o) rel_ok = 1'b0;
        end
        chk("inhibit_hold_released", 32'(rel_ok), 32'd1);
        chk("inhibit_no_clock", 32'(falls - f1), 32'd0);
        bus.ps2_clk_i = 1'b1;
        wait_idle(600, t);
        chk("abort_count", 32'(aborts - a0), 32'd1);

        // Three extended breaks while inhibited: only whole sequences that fit are kept
        bus.ps2_clk_i = 1'b0;
        repeat (4) @(negedge clk_sys);
        d0  = drops;
        f0  = falls;
        occ = 0;
        exp_drops = 0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] code;
            code = 8'($urandom_range(0, 255));
            if (occ + 3 <= FIFO_DEPTH) begin
                occ += 3;
                send_event(1'b0, 1'b1, code, 1'b1);
            end else begin
                exp_drops++;
                send_event(1'b0, 1'b1, code, 1'b0);
            end
            repeat (5) @(negedge clk_sys);
        end
        repeat (5) @(negedge clk_sys);
        chk("fill_fifo_count", 32'(bus.fifo_count), 32'(occ));
        chk("fill_dropped_pulses", 32'(drops - d0), 32'(exp_drops));
        chk("fill_no_clock", 32'(falls - f0), 32'd0);
        bus.ps2_clk_i = 1'b1;
        wait_idle(1500, t);

        // Reset at bit 5 of a frame: lines released, queue flushed, nothing follows
        @(negedge clk_sys);
        send_event(1'b0, 1'b1, 8'h12, 1'b1);
        f0 = falls;
        wait_falls(f0 + 5, 400);
        wait_clk_high(50);
        reset = 1'b1;
        @(negedge clk_sys);
        exp_q.delete();
        chk("midreset_clk_o", 32'(bus.ps2_clk_o), 32'd1);
        chk("midreset_data_o", 32'(bus.ps2_data_o), 32'd1);
        chk("midreset_fifo_count", 32'(bus.fifo_count), 32'd0);
        reset = 1'b0;
        f1 = frames;
        f0 = falls;
        repeat (200) @(negedge clk_sys);
        chk("midreset_no_frame", 32'(frames - f1), 32'd0);
        chk("midreset_no_clock", 32'(falls - f0), 32'd0);
        chk("midreset_busy", 32'(bus.busy), 32'd0);

        // Randomized events in bursts of one or two, with occasional host inhibit
        d0 = drops;
        for (int it = 0; it < 25; it++) begin
            int nev;
            nev = $urandom_range(1, 2);
            for (int e = 0; e < nev; e++) begin
                send_event(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           8'($urandom_range(0, 255)), 1'b1);
                repeat ($urandom_range(1, 6)) @(negedge clk_sys);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(10, 120)) @(negedge clk_sys);
                bus.ps2_clk_i = 1'b0;
                repeat ($urandom_range(3, 25)) @(negedge clk_sys);
                bus.ps2_clk_i = 1'b1;
            end
            wait_idle(2000, t);
        end
        chk("random_no_drops", 32'(drops - d0), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
